// File: rtl/cnu_minfind_stream.sv
// Streaming min/min2 finder for the LDPC check-node unit: folds one sign-magnitude
// message per cycle into a row summary and hands it over through a valid/ready output register.
module cnu_minfind_stream #(
    parameter int DATA_W = 9,
    parameter int D      = 7,
    parameter int IDX_W  = $clog2(D),
    parameter int OFFSET = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-2:0]   out_min,
    output logic [DATA_W-2:0]   out_min2,
    output logic [IDX_W-1:0]    out_idx,
    output logic                out_sign,
    output logic [D-1:0]        out_signs,
    output logic [IDX_W:0]      out_deg,
    output logic                out_err
);

    localparam int MAG_W = DATA_W - 1;
    localparam int CNT_W = IDX_W + 1;
    localparam logic [MAG_W-1:0] OFF_V = MAG_W'(OFFSET);

    logic [CNT_W-1:0] r_cnt;
    logic [MAG_W-1:0] r_min, r_min2;
    logic [IDX_W-1:0] r_idx;
    logic             r_sgn;
    logic [D-1:0]     r_signs;

    logic             r_out_valid;
    logic [MAG_W-1:0] r_out_min, r_out_min2;
    logic [IDX_W-1:0] r_out_idx;
    logic             r_out_sign;
    logic [D-1:0]     r_out_signs;
    logic [CNT_W-1:0] r_out_deg;
    logic             r_out_err;

    logic             w_sign;
    logic [MAG_W-1:0] w_mag;
    logic [IDX_W-1:0] w_pos;
    logic             w_acc, w_close;
    logic [MAG_W-1:0] w_min_n, w_min2_n;
    logic [IDX_W-1:0] w_idx_n;
    logic             w_sgn_n;
    logic [D-1:0]     w_signs_n;

    function automatic logic [MAG_W-1:0] sat_off(input logic [MAG_W-1:0] x);
        return (x > OFF_V) ? x - OFF_V : '0;
    endfunction

    assign w_sign   = in_data[DATA_W-1];
    assign w_mag    = in_data[MAG_W-1:0];
    assign w_pos    = r_cnt[IDX_W-1:0];
    assign in_ready = !r_out_valid || out_ready;
    assign w_acc    = in_valid && in_ready;
    assign w_close  = w_acc && (in_last || r_cnt == CNT_W'(D - 1));

    // Accumulator state with the current beat folded in; the closing beat reads this directly.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_min_n   = r_min;
        w_min2_n  = r_min2;
        w_idx_n   = r_idx;
        w_sgn_n   = r_sgn;
        w_signs_n = r_signs;
        if (r_cnt == '0) begin
            w_min_n      = w_mag;
            w_min2_n     = '1;
            w_idx_n      = '0;
            w_sgn_n      = w_sign;
            w_signs_n    = '0;
            w_signs_n[0] = w_sign;
        end else begin
            if (w_mag < r_min) begin
                w_min2_n = r_min;
                w_min_n  = w_mag;
                w_idx_n  = w_pos;
            end else if (w_mag < r_min2) begin
                w_min2_n = w_mag;
            end
            w_signs_n[w_pos] = w_sign;
            w_sgn_n          = r_sgn ^ w_sign;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_min   <= '0;
            r_min2  <= '0;
            r_idx   <= '0;
            r_sgn   <= 1'b0;
            r_signs <= '0;
        end else if (w_acc) begin
            r_cnt   <= w_close ? '0 : r_cnt + CNT_W'(1);
            r_min   <= w_min_n;
            r_min2  <= w_min2_n;
            r_idx   <= w_idx_n;
            r_sgn   <= w_sgn_n;
            r_signs <= w_signs_n;
        end
    end

    // A closing row overrides the handshake so back-to-back rows keep out_valid high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_min   <= '0;
            r_out_min2  <= '0;
            r_out_idx   <= '0;
            r_out_sign  <= 1'b0;
            r_out_signs <= '0;
            r_out_deg   <= '0;
            r_out_err   <= 1'b0;
        end else if (w_close) begin
            r_out_valid <= 1'b1;
            r_out_min   <= sat_off(w_min_n);
            r_out_min2  <= sat_off(w_min2_n);
            r_out_idx   <= w_idx_n;
            r_out_sign  <= w_sgn_n;
            r_out_signs <= w_signs_n;
            r_out_deg   <= r_cnt + CNT_W'(1);
            r_out_err   <= !in_last;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_min   = r_out_min;
    assign out_min2  = r_out_min2;
    assign out_idx   = r_out_idx;
    assign out_sign  = r_out_sign;
    assign out_signs = r_out_signs;
    assign out_deg   = r_out_deg;
    assign out_err   = r_out_err;

endmodule

// File: tb/tb_cnu_minfind_stream.sv
// Bench for cnu_minfind_stream: two instances (OFFSET 0 and 2) share one input stream and are
// compared every cycle against a row-level model built from sorted magnitude lists.
module tb_cnu_minfind_stream;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_last, out_ready;
    logic [8:0] in_data;

    logic       in_ready, out_valid, out_sign, out_err;
    logic [7:0] out_min, out_min2;
    logic [2:0] out_idx;
    logic [6:0] out_signs;
    logic [3:0] out_deg;

    logic       o2_in_ready, o2_valid, o2_sign, o2_err;
    logic [7:0] o2_min, o2_min2;
    logic [2:0] o2_idx;
    logic [6:0] o2_signs;
    logic [3:0] o2_deg;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cnu_minfind_stream #(.DATA_W(9), .D(7), .OFFSET(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .out_min(out_min), .out_min2(out_min2), .out_idx(out_idx), .out_sign(out_sign),
        .out_signs(out_signs), .out_deg(out_deg), .out_err(out_err)
    );

    cnu_minfind_stream #(.DATA_W(9), .D(7), .OFFSET(2)) u_dut_off (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(o2_in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(o2_valid), .out_ready(out_ready),
        .out_min(o2_min), .out_min2(o2_min2), .out_idx(o2_idx), .out_sign(o2_sign),
        .out_signs(o2_signs), .out_deg(o2_deg), .out_err(o2_err)
    );

    typedef struct {
        int         mn;
        int         mn2;
        int         idx;
        bit         sgn;
        logic [6:0] signs;
        int         deg;
        bit         err;
    } res_t;

    logic [8:0] row_q[$];
    res_t       m_res;
    bit         m_ov;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int offs(input int x, input int off);
        return (x > off) ? x - off : 0;
    endfunction

    function automatic logic [8:0] mk(input bit s, input int m);
        return {s, 8'(m)};
    endfunction

    // Row summary from first principles: sorted magnitudes give min/min2, first occurrence gives idx.
    function automatic res_t model_row(input bit last);
        res_t r;
        int   mags[$];
        r.signs = '0;
        r.sgn   = 1'b0;
        r.idx   = 0;
        r.mn    = int'(row_q[0][7:0]);
        foreach (row_q[i]) begin
            mags.push_back(int'(row_q[i][7:0]));
            r.signs[i] = row_q[i][8];
            r.sgn     ^= row_q[i][8];
            if (int'(row_q[i][7:0]) < r.mn) begin
                r.mn  = int'(row_q[i][7:0]);
                r.idx = i;
            end
        end
        mags.sort();
        r.mn2 = (mags.size() > 1) ? mags[1] : 255;
        r.deg = row_q.size();
        r.err = !last;
        return r;
    endfunction

    task automatic chk_out();
        check("out_valid", out_valid, m_ov);
        check("out_valid_off2", o2_valid, m_ov);
        if (m_ov) begin
            check("out_min", out_min, m_res.mn);
            check("out_min2", out_min2, m_res.mn2);
            check("out_idx", out_idx, m_res.idx);
            check("out_sign", out_sign, m_res.sgn);
            check("out_signs", out_signs, m_res.signs);
            check("out_deg", out_deg, m_res.deg);
            check("out_err", out_err, m_res.err);
            check("off2_min", o2_min, offs(m_res.mn, 2));
            check("off2_min2", o2_min2, offs(m_res.mn2, 2));
            check("off2_idx", o2_idx, m_res.idx);
        end
    endtask

    // Drive one cycle from a negedge, predict acceptance, then check outputs at the next negedge.
    task automatic step(input bit v, input logic [8:0] d, input bit last, input bit ordy);
        bit acc, close;
        in_valid  = v;
        in_data   = d;
        in_last   = last;
        out_ready = ordy;
        #1;
        check("in_ready", in_ready, !m_ov || ordy);
        check("in_ready_off2", o2_in_ready, !m_ov || ordy);
        acc   = v && (!m_ov || ordy);
        close = 1'b0;
        if (acc) begin
            row_q.push_back(d);
            if (last || row_q.size() == 7) begin
                close = 1'b1;
                m_res = model_row(last);
                row_q.delete();
            end
        end
        if (close) m_ov = 1'b1;
        else if (ordy) m_ov = 1'b0;
        @(negedge clk);
        chk_out();
    endtask

    task automatic chk_zero(input string tag);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_min"}, out_min, 0);
        check({tag, "_min2"}, out_min2, 0);
        check({tag, "_signs"}, out_signs, 0);
        check({tag, "_deg"}, out_deg, 0);
        check({tag, "_in_ready"}, in_ready, 1);
    endtask

    initial begin
        int mags1[7]  = '{5, 3, 9, 3, 12, 1, 7};
        bit sgns1[7]  = '{0, 1, 0, 0, 1, 1, 0};
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        m_ov      = 1'b0;
        #12;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Full-degree row from the reference example.
        for (int i = 0; i < 7; i++) step(1, mk(sgns1[i], mags1[i]), i == 6, 1);
        check("ex_min", out_min, 1);
        check("ex_min2", out_min2, 3);
        check("ex_idx", out_idx, 5);
        check("ex_sign", out_sign, 1);
        check("ex_signs", out_signs, 7'b0110010);
        check("ex_deg", out_deg, 7);
        check("ex_err", out_err, 0);

        // Ties keep the earliest edge; equal value becomes min2.
        for (int i = 0; i < 3; i++) step(1, mk(0, 4), i == 2, 1);
        check("tie_min", out_min, 4);
        check("tie_min2", out_min2, 4);
        check("tie_idx", out_idx, 0);

        step(1, mk(1, 6), 1, 1);
        check("deg1_min", out_min, 6);
        check("deg1_min2", out_min2, 255);
        check("deg1_deg", out_deg, 1);
        check("deg1_off2_min2", o2_min2, 253);

        step(1, mk(0, 1), 0, 1);
        step(1, mk(0, 5), 1, 1);
        check("off2_lit_min", o2_min, 0);
        check("off2_lit_min2", o2_min2, 3);

        // Back-pressure: result held, input stalled, then released into a new row.
        step(1, mk(0, 2), 0, 1);
        step(1, mk(1, 8), 1, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, mk(0, 20 + i), 0, 0);
            check("bp_in_ready", in_ready, 0);
            check("bp_hold_min2", out_min2, 8);
        end
        step(1, mk(1, 30), 0, 1);
        step(1, mk(0, 11), 1, 1);
        check("bp_after_min", out_min, 11);
        check("bp_after_deg", out_deg, 2);

        // Back-to-back single-beat rows: valid never drops.
        for (int i = 0; i < 4; i++) begin
            step(1, mk(i[0], 40 + i), 1, 1);
            check("b2b_valid", out_valid, 1);
            check("b2b_min", out_min, 40 + i);
        end

        // Forced close at D, then the next beat starts a fresh row.
        for (int i = 0; i < 7; i++) step(1, mk(0, 10 - i), 0, 1);
        check("forced_err", out_err, 1);
        check("forced_min", out_min, 4);
        check("forced_idx", out_idx, 6);
        step(1, mk(0, 9), 1, 1);
        check("after_forced_idx", out_idx, 0);
        check("after_forced_deg", out_deg, 1);
        check("after_forced_err", out_err, 0);

        // Reset mid-row drops the partial row.
        for (int i = 0; i < 3; i++) step(1, mk(1, 1), 0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("midreset");
        in_valid = 1'b0;
        row_q.delete();
        m_ov = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step(1, mk(0, 50 + 3 * i), i == 3, 1);
        check("postreset_min", out_min, 50);
        check("postreset_min2", out_min2, 53);
        check("postreset_deg", out_deg, 4);
        check("postreset_sign", out_sign, 0);

        // Random traffic with irregular degrees, ties and back-pressure.
        for (int n = 0; n < 3000; n++) begin
            int m;
            m = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(0, 255);
            step($urandom_range(0, 3) != 0, mk($urandom_range(0, 1), m),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 7);
        end
        step(0, '0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
